button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Turns the four debounced button levels into discrete, timestamp-free user events (press, long-press, auto-repeat, release) and hands them one at a time to the camera control logic over a valid/ready interface. Sits directly after the 4-button debouncer and ahead of the menu/register-configuration sequencer. It owns the millisecond timebase for hold detection, and arbitrates the four buttons round-robin onto one event channel.

## Interface
- TICK_DIV, 50000: clk cycles per 1 ms tick; 1..65535.
- LONG_MS, 750: hold time in ticks before LONG; 2..1023.
- REPEAT_MS, 150: ticks between REPEAT events while held; 1..1023.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_level  in  4  debounced button levels; 1 = pressed.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event when evt_valid && evt_ready.
- evt_btn  out  2  button index of event.
- evt_kind  out  2  0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE.
- overrun  out  4  sticky per-button flag: a non-REPEAT event overwrote an unconsumed one.
- ovr_clr  in  1  one-cycle pulse; clears all overrun bits.

## Operation
- Tick generator: 16-bit counter 0..TICK_DIV-1; tick pulses one cycle on wrap. Shared by all buttons.
- btn_level sampled into prev register each cycle; rise = level & ~prev, fall = ~level & prev. prev resets to 0.
- Per-button FSM, states IDLE, PRESSED, HELD; 10-bit hold counter:
  - IDLE: rise -> post PRESS, counter = 0, go PRESSED.
  - PRESSED: counter +1 per tick; counter reaches LONG_MS -> post LONG, counter = 0, go HELD.
  - HELD: counter +1 per tick; reaches REPEAT_MS -> post REPEAT, counter = 0.
  - PRESSED/HELD: fall -> post RELEASE, go IDLE; fall has priority over a same-cycle LONG/REPEAT threshold (threshold event suppressed).
- Per-button pending slot (valid + kind). Posting into occupied slot: REPEAT is silently dropped; any other kind overwrites and sets overrun[i]. Posting and draining the same slot in one cycle: drain takes old content, new event fills slot, no overrun.
- Arbiter: round-robin over slots with valid set, starting one past last-granted index (pointer resets to 3, so button 0 first). Grant moves slot content into output register when output register empty or being drained this cycle.
- Output register holds evt_btn/evt_kind stable while evt_valid=1 and evt_ready=0.
- overrun: set beats ovr_clr in same cycle.

## Timing
- Reset values: evt_valid 0, evt_btn 0, evt_kind 0, overrun 0; all FSMs IDLE, slots empty, counters 0.
- Latency: btn_level change at edge N -> slot valid after edge N+1 -> evt_valid after edge N+2 (output empty).
- Back-to-back: one event per cycle sustained when evt_ready held 1.
- LONG after LONG_MS ticks from PRESS (LONG_MS-1 to LONG_MS ms wall time, tick phase-dependent); REPEAT every REPEAT_MS ticks thereafter.
- Reset mid-operation clears everything; a button held through rst_n release produces PRESS 2 cycles later.

## Structure
- Package button_pkg: NUM_BTN = 4, evt_kind encodings (EVT_PRESS/LONG/REPEAT/RELEASE), FSM state enum.
- Sub-module button_event_fsm (edge detect, FSM, hold counter, pending slot, overrun bit), instantiated 4x; tick generator, arbiter, output register in top.

## Test plan
Sim params TICK_DIV=4, LONG_MS=10, REPEAT_MS=3, evt_ready=1 unless stated.
- Tap btn 2 for 20 cycles -> PRESS(2) at +2 cycles, RELEASE(2) 2 cycles after fall, no LONG.
- Hold btn 0 for 80 cycles -> PRESS, LONG after 10 ticks (~40 cycles), REPEAT every 12 cycles, RELEASE; exact count checked against tick phase.
- All four rise same cycle -> PRESS for btn 0,1,2,3 on four consecutive cycles; then btn 1,3 release together -> RELEASE(1), RELEASE(3) in RR order.
- evt_ready=0 for 200 cycles while btn 1 held -> first PRESS held stable, REPEATs dropped, overrun[1]=0; release -> overrun[1]=1; ovr_clr -> 0.
- Release exactly on LONG threshold tick -> RELEASE only, no LONG.
- rst_n low mid-HELD with btn 3 still pressed -> outputs 0 immediately (async); after release PRESS(3) at +2 cycles.

Source files
------------

// File: rtl/button_event_ctrl_pkg.sv
// Shared constants and types for the button event controller.
// Event kind encodings match the evt_kind port values.
package button_pkg;

    localparam int unsigned NUM_BTN = 4;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } btn_state_e;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event channel from the button controller to the menu sequencer.
// Valid/ready handshake; an event transfers when both are high.
interface button_event_ctrl_if;
    import button_pkg::*;

    logic                       evt_valid;
    logic                       evt_ready;
    logic [$clog2(NUM_BTN)-1:0] evt_btn;
    logic [1:0]                 evt_kind;

    modport master (output evt_valid, output evt_btn, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_btn, input evt_kind, output evt_ready);

endinterface

// File: rtl/button_event_ctrl_fsm.sv
// Per-button edge detect, press/long/repeat FSM with hold counter,
// single-entry pending event slot and sticky overrun flag.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned LONG_MS   = 750,
    parameter int unsigned REPEAT_MS = 150
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      level_i,
    input  logic      tick_i,
    input  logic      grant_i,
    input  logic      ovr_clr_i,
    output logic      pend_o,
    output evt_kind_e kind_o,
    output logic      ovr_o
);
    localparam logic [9:0] LONG_C = 10'(LONG_MS);
    localparam logic [9:0] REP_C  = 10'(REPEAT_MS);

    btn_state_e state_q, state_d;
    logic [9:0] cnt_q, cnt_d, cnt_inc;
    logic       prev_q;
    logic       slot_v_q, slot_v_d;
    evt_kind_e  slot_k_q, slot_k_d;
    logic       ovr_q, ovr_d;
    logic       rise, fall, post;
    evt_kind_e  post_kind;

    assign rise    = level_i & ~prev_q;
    assign fall    = ~level_i & prev_q;
    assign cnt_inc = cnt_q + 10'd1;

    // Fall is tested before the tick so a release on a threshold tick
    // suppresses the LONG/REPEAT that would otherwise fire.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        post      = 1'b0;
        post_kind = EVT_PRESS;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    post    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    post      = 1'b1;
                    post_kind = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end else if (tick_i) begin
                    if (cnt_inc == LONG_C) begin
                        post      = 1'b1;
                        post_kind = EVT_LONG;
                        cnt_d     = '0;
                        state_d   = ST_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_HELD: begin
                if (fall) begin
                    post      = 1'b1;
                    post_kind = EVT_RELEASE;
                    state_d   = ST_IDLE;
                end else if (tick_i) begin
                    if (cnt_inc == REP_C) begin
                        post      = 1'b1;
                        post_kind = EVT_REPEAT;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A slot being drained this cycle counts as free for the new event.
    always_comb begin
        slot_v_d = slot_v_q;
        slot_k_d = slot_k_q;
        ovr_d    = ovr_q;
        if (ovr_clr_i) ovr_d = 1'b0;
        if (grant_i) slot_v_d = 1'b0;
        if (post) begin
            if (slot_v_q && !grant_i) begin
                if (post_kind != EVT_REPEAT) begin
                    slot_k_d = post_kind;
                    ovr_d    = 1'b1;
                end
            end else begin
                slot_v_d = 1'b1;
                slot_k_d = post_kind;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            slot_v_q <= 1'b0;
            slot_k_q <= EVT_PRESS;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= level_i;
            slot_v_q <= slot_v_d;
            slot_k_q <= slot_k_d;
            ovr_q    <= ovr_d;
        end
    end

    assign pend_o = slot_v_q;
    assign kind_o = slot_k_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller top: ms tick generator, four per-button FSMs,
// round-robin arbiter and the registered valid/ready output stage.
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned LONG_MS   = 750,
    parameter int unsigned REPEAT_MS = 150
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_level,
    button_event_ctrl_if.master        evt,
    output logic [NUM_BTN-1:0]         overrun,
    input  logic                       ovr_clr
);
    localparam int unsigned IDX_W     = $clog2(NUM_BTN);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0]        tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [NUM_BTN-1:0] pend, grant;
    evt_kind_e          pend_kind [NUM_BTN];
    logic [IDX_W-1:0]   ptr_q, ptr_d, sel, cand;
    logic               found, load;
    logic               out_v_q, out_v_d;
    logic [IDX_W-1:0]   out_btn_q, out_btn_d;
    evt_kind_e          out_kind_q, out_kind_d;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_event_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .level_i   (btn_level[i]),
            .tick_i    (tick),
            .grant_i   (grant[i]),
            .ovr_clr_i (ovr_clr),
            .pend_o    (pend[i]),
            .kind_o    (pend_kind[i]),
            .ovr_o     (overrun[i])
        );
    end

    // Search starts one past the last grant; index arithmetic wraps mod NUM_BTN.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int unsigned k = 1; k <= NUM_BTN; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && pend[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign load = found & (~out_v_q | evt.evt_ready);

    always_comb begin
        out_v_d    = out_v_q;
        out_btn_d  = out_btn_q;
        out_kind_d = out_kind_q;
        ptr_d      = ptr_q;
        grant      = '0;
        if (out_v_q && evt.evt_ready) out_v_d = 1'b0;
        if (load) begin
            out_v_d    = 1'b1;
            out_btn_d  = sel;
            out_kind_d = pend_kind[sel];
            ptr_d      = sel;
            grant[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            ptr_q      <= IDX_W'(NUM_BTN - 1);
            out_v_q    <= 1'b0;
            out_btn_q  <= '0;
            out_kind_q <= EVT_PRESS;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ptr_q      <= ptr_d;
            out_v_q    <= out_v_d;
            out_btn_q  <= out_btn_d;
            out_kind_q <= out_kind_d;
        end
    end

    assign evt.evt_valid = out_v_q;
    assign evt.evt_btn   = out_btn_q;
    assign evt.evt_kind  = out_kind_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: directed scenarios plus a
// randomized run scored against a tick-count reference model.
module tb_button_event_ctrl;
    import button_pkg::*;

    localparam int TD = 4;
    localparam int LM = 10;
    localparam int RM = 3;

    typedef struct { logic [1:0] kind; int cyc; } exp_t;
    typedef struct { logic [1:0] btn; logic [1:0] kind; int cyc; } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_level = '0;
    logic [3:0] overrun;
    logic       ovr_clr = 1'b0;

    button_event_ctrl_if evt_if ();

    button_event_ctrl #(.TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_level (btn_level),
        .evt       (evt_if),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    exp_t     exp_q [4][$];
    obs_t     obs_q [$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       cyc_k = 0;
    bit       mdl_en = 1'b0;
    bit       chk_lat = 1'b0;
    bit [3:0] mprev = '0;
    int       held [4];

    // Called at a falling edge: drives this cycle's inputs, logs the handshake
    // that completes on the next rising edge, and advances the reference model.
    task automatic drive_cycle(input logic [3:0] lvl, input logic rdy, input logic clr);
        obs_t       o;
        exp_t       e;
        bit         tick, hit;
        logic [1:0] pk;
        btn_level = lvl;
        evt_if.evt_ready = rdy;
        ovr_clr = clr;
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            o.btn = evt_if.evt_btn;
            o.kind = evt_if.evt_kind;
            o.cyc = cyc_k;
            obs_q.push_back(o);
            if (mdl_en) begin
                n_chk++;
                if (exp_q[o.btn].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got btn=%0d kind=%0d at cycle %0d, required no event",
                             o.btn, o.kind, o.cyc);
                end else begin
                    e = exp_q[o.btn].pop_front();
                    if (o.kind !== e.kind) begin
                        n_fail++;
                        $display("FAIL event_kind btn=%0d: got %0d, required %0d", o.btn, o.kind, e.kind);
                    end
                    if (chk_lat) begin
                        n_chk++;
                        if (o.cyc - e.cyc != 2) begin
                            n_fail++;
                            $display("FAIL event_latency btn=%0d: got %0d cycles, required 2", o.btn, o.cyc - e.cyc);
                        end
                    end
                end
            end
        end
        tick = ((cyc_k % TD) == TD - 1);
        for (int b = 0; b < 4; b++) begin
            hit = 1'b0;
            pk = EVT_PRESS;
            if (lvl[b] && !mprev[b]) begin
                hit = 1'b1; pk = EVT_PRESS; held[b] = 0;
            end else if (!lvl[b] && mprev[b]) begin
                hit = 1'b1; pk = EVT_RELEASE;
            end else if (lvl[b] && tick) begin
                held[b]++;
                if (held[b] == LM) begin
                    hit = 1'b1; pk = EVT_LONG;
                end else if (held[b] > LM && ((held[b] - LM) % RM) == 0) begin
                    hit = 1'b1; pk = EVT_REPEAT;
                end
            end
            if (hit && mdl_en) begin
                e.kind = pk;
                e.cyc = cyc_k;
                exp_q[b].push_back(e);
            end
        end
        mprev = lvl;
        cyc_k++;
    endtask

    task automatic step(input logic [3:0] lvl, input logic rdy, input logic clr);
        @(negedge clk);
        drive_cycle(lvl, rdy, clr);
    endtask

    // Holds reset for two cycles; the release cycle itself uses 'lvl'.
    task automatic do_reset(input logic [3:0] lvl);
        @(negedge clk);
        rst_n = 1'b0;
        btn_level = lvl;
        ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc_k = 0;
        mprev = '0;
        for (int b = 0; b < 4; b++) exp_q[b].delete();
        obs_q.delete();
        drive_cycle(lvl, 1'b1, 1'b0);
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int b = 0; b < 4; b++) s += exp_q[b].size();
        return s;
    endfunction

    task automatic test_reset();
        mdl_en = 1'b1; chk_lat = 1'b1;
        do_reset('0);
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", evt_if.evt_valid); end
        n_chk++; if (evt_if.evt_btn !== 2'd0) begin n_fail++; $display("FAIL reset_btn: got %0d, required 0", evt_if.evt_btn); end
        n_chk++; if (evt_if.evt_kind !== 2'd0) begin n_fail++; $display("FAIL reset_kind: got %0d, required 0", evt_if.evt_kind); end
        n_chk++; if (overrun !== 4'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0000", overrun); end
        repeat (6) step('0, 1'b1, 1'b0);
        n_chk++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b, required 0", evt_if.evt_valid); end
    endtask

    task automatic test_tap();
        int r;
        mdl_en = 1'b1; chk_lat = 1'b1;
        do_reset('0);
        r = cyc_k;
        repeat (20) step(4'b0100, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);
        n_chk++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL tap_count: got %0d events, required 2", obs_q.size());
        end else begin
            n_chk++;
            if (obs_q[0].btn !== 2'd2 || obs_q[0].kind !== EVT_PRESS || obs_q[0].cyc != r + 2) begin
                n_fail++; $display("FAIL tap_press: got btn=%0d kind=%0d cyc=%0d, required btn=2 kind=0 cyc=%0d",
                                   obs_q[0].btn, obs_q[0].kind, obs_q[0].cyc, r + 2);
            end
            n_chk++;
            if (obs_q[1].btn !== 2'd2 || obs_q[1].kind !== EVT_RELEASE || obs_q[1].cyc != r + 22) begin
                n_fail++; $display("FAIL tap_release: got btn=%0d kind=%0d cyc=%0d, required btn=2 kind=3 cyc=%0d",
                                   obs_q[1].btn, obs_q[1].kind, obs_q[1].cyc, r + 22);
            end
        end
        n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL tap_missing: got %0d outstanding, required 0", outstanding()); end
    endtask

    task automatic test_hold();
        int p_cyc, last, n_long, n_rep;
        mdl_en = 1'b1; chk_lat = 1'b1;
        do_reset('0);
        repeat (80) step(4'b0001, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);
        p_cyc = 0; last = 0; n_long = 0; n_rep = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].kind == EVT_PRESS) p_cyc = obs_q[i].cyc;
            if (obs_q[i].kind == EVT_LONG) begin
                n_long++;
                n_chk++;
                if (obs_q[i].cyc - p_cyc < (LM - 1) * TD + 1 || obs_q[i].cyc - p_cyc > LM * TD) begin
                    n_fail++; $display("FAIL hold_long_time: got %0d cycles after press, required %0d..%0d",
                                       obs_q[i].cyc - p_cyc, (LM - 1) * TD + 1, LM * TD);
                end
                last = obs_q[i].cyc;
            end
            if (obs_q[i].kind == EVT_REPEAT) begin
                n_rep++;
                n_chk++;
                if (obs_q[i].cyc - last != RM * TD) begin
                    n_fail++; $display("FAIL hold_repeat_gap: got %0d cycles, required %0d", obs_q[i].cyc - last, RM * TD);
                end
                last = obs_q[i].cyc;
            end
        end
        n_chk++; if (n_long != 1) begin n_fail++; $display("FAIL hold_long_count: got %0d, required 1", n_long); end
        n_chk++; if (n_rep < 3) begin n_fail++; $display("FAIL hold_repeat_count: got %0d, required at least 3", n_rep); end
        n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL hold_missing: got %0d outstanding, required 0", outstanding()); end
    endtask

    task automatic test_all_rise();
        int r;
        mdl_en = 1'b1; chk_lat = 1'b0;
        do_reset('0);
        step(4'b0000, 1'b1, 1'b0);
        r = cyc_k;
        repeat (10) step(4'b1111, 1'b1, 1'b0);
        repeat (6) step(4'b0101, 1'b1, 1'b0);
        n_chk++;
        if (obs_q.size() < 6) begin
            n_fail++; $display("FAIL rr_count: got %0d events, required 6", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (obs_q[i].btn !== 2'(i) || obs_q[i].kind !== EVT_PRESS || obs_q[i].cyc != r + 2 + i) begin
                    n_fail++; $display("FAIL rr_press%0d: got btn=%0d kind=%0d cyc=%0d, required btn=%0d kind=0 cyc=%0d",
                                       i, obs_q[i].btn, obs_q[i].kind, obs_q[i].cyc, i, r + 2 + i);
                end
            end
            n_chk++;
            if (obs_q[4].btn !== 2'd1 || obs_q[4].kind !== EVT_RELEASE || obs_q[5].btn !== 2'd3 || obs_q[5].kind !== EVT_RELEASE) begin
                n_fail++; $display("FAIL rr_release: got btn %0d,%0d kinds %0d,%0d, required btn 1,3 kinds 3,3",
                                   obs_q[4].btn, obs_q[5].btn, obs_q[4].kind, obs_q[5].kind);
            end
        end
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL rr_missing: got %0d outstanding, required 0", outstanding()); end
    endtask

    task automatic test_stall();
        mdl_en = 1'b0; chk_lat = 1'b0;
        do_reset('0);
        for (int i = 0; i < 200; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            if (i >= 2 && (i % 20) == 0) begin
                n_chk++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd1 || evt_if.evt_kind !== EVT_PRESS) begin
                    n_fail++; $display("FAIL stall_hold: got valid=%b btn=%0d kind=%0d, required valid=1 btn=1 kind=0",
                                       evt_if.evt_valid, evt_if.evt_btn, evt_if.evt_kind);
                end
            end
        end
        n_chk++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL stall_no_overrun: got %b, required 0000", overrun); end
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        n_chk++; if (overrun !== 4'b0010) begin n_fail++; $display("FAIL stall_overrun: got %b, required 0010", overrun); end
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        n_chk++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear: got %b, required 0000", overrun); end
        repeat (5) step(4'b0000, 1'b1, 1'b0);
        n_chk++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL stall_drain_count: got %0d events, required 2", obs_q.size());
        end else begin
            n_chk++;
            if (obs_q[0].kind !== EVT_PRESS || obs_q[1].kind !== EVT_RELEASE || obs_q[1].btn !== 2'd1) begin
                n_fail++; $display("FAIL stall_drain_kinds: got %0d,%0d, required 0,3", obs_q[0].kind, obs_q[1].kind);
            end
        end
    endtask

    task automatic test_release_on_long();
        int r, t1, f, n_long, n_rel;
        for (int off = 0; off < 2; off++) begin
            mdl_en = 1'b1; chk_lat = 1'b1;
            do_reset('0);
            r = cyc_k;
            t1 = r + 1;
            while ((t1 % TD) != TD - 1) t1++;
            f = t1 + (LM - 1) * TD + off;
            while (cyc_k < f) step(4'b0001, 1'b1, 1'b0);
            repeat (6) step(4'b0000, 1'b1, 1'b0);
            n_long = 0; n_rel = 0;
            foreach (obs_q[i]) begin
                if (obs_q[i].kind == EVT_LONG) n_long++;
                if (obs_q[i].kind == EVT_RELEASE) n_rel++;
            end
            n_chk++; if (n_long != off) begin n_fail++; $display("FAIL threshold_long off=%0d: got %0d LONG, required %0d", off, n_long, off); end
            n_chk++; if (n_rel != 1) begin n_fail++; $display("FAIL threshold_release off=%0d: got %0d, required 1", off, n_rel); end
            n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL threshold_missing: got %0d outstanding, required 0", outstanding()); end
        end
    endtask

    task automatic test_reset_mid();
        mdl_en = 1'b0; chk_lat = 1'b0;
        do_reset('0);
        repeat (60) step(4'b1000, 1'b0, 1'b0);
        n_chk++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd3) begin
            n_fail++; $display("FAIL mid_pre: got valid=%b btn=%0d, required valid=1 btn=3", evt_if.evt_valid, evt_if.evt_btn);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_btn !== 2'd0 || evt_if.evt_kind !== 2'd0) begin
            n_fail++; $display("FAIL async_reset_out: got valid=%b btn=%0d kind=%0d, required 0 0 0",
                               evt_if.evt_valid, evt_if.evt_btn, evt_if.evt_kind);
        end
        n_chk++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL async_reset_ovr: got %b, required 0000", overrun); end
        mdl_en = 1'b1; chk_lat = 1'b1;
        do_reset(4'b1000);
        repeat (5) step(4'b1000, 1'b1, 1'b0);
        n_chk++;
        if (obs_q.size() < 1) begin
            n_fail++; $display("FAIL held_press: got no event, required PRESS(3)");
        end else if (obs_q[0].btn !== 2'd3 || obs_q[0].kind !== EVT_PRESS || obs_q[0].cyc != 2) begin
            n_fail++; $display("FAIL held_press: got btn=%0d kind=%0d cyc=%0d, required btn=3 kind=0 cyc=2",
                               obs_q[0].btn, obs_q[0].kind, obs_q[0].cyc);
        end
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL mid_missing: got %0d outstanding, required 0", outstanding()); end
    endtask

    // Levels only change on tick cycles, so every slot drains before its
    // button can post again and the model never sees a drop or overwrite.
    task automatic test_random();
        logic [3:0] lvl;
        mdl_en = 1'b1; chk_lat = 1'b0;
        do_reset('0);
        lvl = '0;
        for (int i = 0; i < 800; i++) begin
            if ((cyc_k % TD) == TD - 1) begin
                for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) lvl[b] = ~lvl[b];
            end
            step(lvl, 1'b1, 1'b0);
        end
        while ((cyc_k % TD) != TD - 1) step(lvl, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        n_chk++; if (obs_q.size() < 20) begin n_fail++; $display("FAIL random_activity: got %0d events, required at least 20", obs_q.size()); end
        n_chk++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL random_overrun: got %b, required 0000", overrun); end
        n_chk++; if (outstanding() != 0) begin n_fail++; $display("FAIL random_missing: got %0d outstanding, required 0", outstanding()); end
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        for (int b = 0; b < 4; b++) held[b] = 0;
        test_reset();
        test_tap();
        test_hold();
        test_all_rise();
        test_stall();
        test_release_on_long();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
